// File: rtl/mean_filter_frame_ctrl.sv
// Frame sequencer around the 3x3 mean filter: feeds one frame plus flush lines,
// regenerates sof/eol/eof on the filter output by counting, and flags errors.
module mean_filter_frame_ctrl #(
  parameter int FLUSH_LINES = 1,
  parameter int TIMEOUT     = 4095,
  parameter int DATA_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       img_width,
  input  logic [9:0]        img_height,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              flt_valid_o,
  output logic [DATA_W-1:0] flt_data_o,
  input  logic              flt_valid_i,
  input  logic [DATA_W-1:0] flt_data_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              err_cfg,
  output logic              err_timeout,
  output logic              err_overrun
);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;

  localparam logic [9:0]  FL_LAST = 10'(FLUSH_LINES - 1);
  localparam logic [11:0] TO_LIM  = 12'(TIMEOUT);

  state_t      state, state_nx;
  logic [10:0] w_r, ix, fx, ox;
  logic [9:0]  h_r, iy, fl, oy;
  logic [11:0] tcnt;
  logic        ofin;

  logic [10:0] w_last;
  logic [9:0]  h_last;
  logic [11:0] tcnt_inc;
  logic        start_ok, cfg_bad, feed_beat, in_last, flush_beat, flush_last;
  logic        out_active, out_beat, out_over, o_first, o_eol, o_last, timeout_hit;

  assign in_ready = (state == S_FEED);

  always_comb begin
    w_last      = w_r - 11'd1;
    h_last      = h_r - 10'd1;
    tcnt_inc    = tcnt + 12'd1;
    start_ok    = start && (state == S_IDLE);
    cfg_bad     = (img_width < 11'd2) || (img_height < 10'd2);
    feed_beat   = (state == S_FEED) && in_valid;
    in_last     = feed_beat && (ix == w_last) && (iy == h_last);
    flush_beat  = (state == S_FLUSH);
    flush_last  = flush_beat && (fx == w_last) && (fl == FL_LAST);
    out_active  = (state == S_FEED) || (state == S_FLUSH) || (state == S_DRAIN);
    out_beat    = out_active && flt_valid_i && !ofin;
    out_over    = out_active && flt_valid_i && ofin;
    o_first     = (ox == 11'd0) && (oy == 10'd0);
    o_eol       = (ox == w_last);
    o_last      = o_eol && (oy == h_last);
    // A beat in the same cycle clears the idle count, so the final pixel beats a timeout.
    timeout_hit = (state == S_DRAIN) && !ofin && !flt_valid_i && (tcnt_inc == TO_LIM);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = cfg_bad ? S_DONE : S_FEED;
      S_FEED:  if (in_last) state_nx = (FLUSH_LINES == 0) ? S_DRAIN : S_FLUSH;
      S_FLUSH: if (flush_last) state_nx = S_DRAIN;
      S_DRAIN: if (ofin || timeout_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Control: handshake, frame counters, sticky errors
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      w_r         <= '0;
      h_r         <= '0;
      ix          <= '0;
      iy          <= '0;
      fx          <= '0;
      fl          <= '0;
      ox          <= '0;
      oy          <= '0;
      ofin        <= 1'b0;
      tcnt        <= '0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) busy <= 1'b0;

      if (start_ok) begin
        busy        <= 1'b1;
        w_r         <= img_width;
        h_r         <= img_height;
        ix          <= '0;
        iy          <= '0;
        fx          <= '0;
        fl          <= '0;
        ox          <= '0;
        oy          <= '0;
        ofin        <= 1'b0;
        err_cfg     <= cfg_bad;
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end

      if (feed_beat) begin
        if (ix == w_last) begin
          ix <= '0;
          iy <= iy + 10'd1;
        end else begin
          ix <= ix + 11'd1;
        end
      end

      if (flush_beat) begin
        if (fx == w_last) begin
          fx <= '0;
          fl <= fl + 10'd1;
        end else begin
          fx <= fx + 11'd1;
        end
      end

      if (out_beat) begin
        if (o_eol) begin
          ox <= '0;
          oy <= oy + 10'd1;
        end else begin
          ox <= ox + 11'd1;
        end
        if (o_last) ofin <= 1'b1;
      end

      if ((state != S_DRAIN) || flt_valid_i) tcnt <= '0;
      else                                   tcnt <= tcnt_inc;

      if (timeout_hit) err_timeout <= 1'b1;
      if (out_over)    err_overrun <= 1'b1;
    end
  end

  // Stage p0 -> filter input and filter output -> frame output, one register each
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_valid_o <= 1'b0;
      flt_data_o  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_eof     <= 1'b0;
    end else begin
      flt_valid_o <= feed_beat || flush_beat;
      flt_data_o  <= feed_beat ? in_data : '0;
      out_valid   <= out_beat;
      out_sof     <= out_beat && o_first;
      out_eol     <= out_beat && o_eol;
      out_eof     <= out_beat && o_last;
      if (out_beat) out_data <= flt_data_i;
    end
  end

endmodule

// File: tb/tb_mean_filter_frame_ctrl.sv
// Scoreboard bench for mean_filter_frame_ctrl with a fixed-latency filter model.
module tb_mean_filter_frame_ctrl;

  localparam int LAT = 1287;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] img_width = '0;
  logic [9:0]  img_height = '0;
  logic        start = 1'b0;
  logic        busy, done;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready;
  logic        flt_valid_o;
  logic [23:0] flt_data_o;
  logic        flt_valid_i = 1'b0;
  logic [23:0] flt_data_i = '0;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_sof, out_eol, out_eof;
  logic        err_cfg, err_timeout, err_overrun;

  always #5 clk = ~clk;

  mean_filter_frame_ctrl #(.FLUSH_LINES(1), .TIMEOUT(4095), .DATA_W(24)) dut (
    .clk(clk), .reset(reset), .img_width(img_width), .img_height(img_height),
    .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flt_valid_o(flt_valid_o), .flt_data_o(flt_data_o),
    .flt_valid_i(flt_valid_i), .flt_data_i(flt_data_i),
    .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .err_cfg(err_cfg), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  typedef struct packed { logic [31:0] due; logic [23:0] d; } beat_t;
  typedef struct packed { logic sof; logic eol; logic eof; logic [23:0] d; } opix_t;

  beat_t flt_q[$];
  beat_t mdl_q[$];
  opix_t out_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_emit = 0;
  int mdl_cnt = 0;
  int last_eof_cyc = -100000;
  int last_out_cyc = -100000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors and filter model, all sampled on the falling edge
  beat_t b;
  opix_t o;
  always @(negedge clk) begin
    if (reset) begin
      mdl_q.delete();
      flt_valid_i = 1'b0;
      flt_data_i  = '0;
    end else begin
      if (flt_valid_o) begin
        chk("flt_expected", 32'(flt_q.size() > 0), 32'd1);
        if (flt_q.size() > 0) begin
          b = flt_q.pop_front();
          chk("flt_data", 32'(flt_data_o), 32'(b.d));
          chk("flt_cycle", 32'(cyc), b.due);
        end
        if (mdl_cnt < n_emit) begin
          b.due = 32'(cyc + LAT);
          b.d   = flt_data_o ^ 24'hA5A5A5;
          mdl_q.push_back(b);
        end
        mdl_cnt++;
      end
      if (out_valid) begin
        chk("out_expected", 32'(out_q.size() > 0), 32'd1);
        if (out_q.size() > 0) begin
          o = out_q.pop_front();
          chk("out_data", 32'(out_data), 32'(o.d));
          chk("out_flags", 32'({out_sof, out_eol, out_eof}), 32'({o.sof, o.eol, o.eof}));
        end
        if (out_eof) last_eof_cyc = cyc;
        last_out_cyc = cyc;
      end
      if (mdl_q.size() > 0 && int'(mdl_q[0].due) <= cyc) begin
        flt_valid_i = 1'b1;
        flt_data_i  = mdl_q[0].d;
        void'(mdl_q.pop_front());
      end else begin
        flt_valid_i = 1'b0;
        flt_data_i  = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h, input int emit);
    img_width  = 11'(w);
    img_height = 10'(h);
    n_emit     = emit;
    mdl_cnt    = 0;
    last_eof_cyc = -100000;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int emit, input int n_send,
                            input bit gaps, input logic [7:0] tag);
    logic [23:0] pix;
    beat_t  fb;
    opix_t  op;
    int     last_edge;
    last_edge = 0;
    for (int k = 0; k < n_send; k++) begin
      pix = {tag, 8'(k), 8'(k * 7 + 3)};
      in_valid = 1'b1;
      in_data  = pix;
      for (int n = 0; n < 100 && !in_ready; n++) tick();
      chk("in_ready_feed", 32'(in_ready), 32'd1);
      fb.due = 32'(cyc + 1);
      fb.d   = pix;
      flt_q.push_back(fb);
      last_edge = cyc + 1;
      if (k < emit) begin
        op.sof = (k == 0);
        op.eol = ((k % w) == w - 1);
        op.eof = (k == w * h - 1);
        op.d   = pix ^ 24'hA5A5A5;
        out_q.push_back(op);
      end
      tick();
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = '0;
        tick();
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (n_send == w * h) begin
      for (int j = 1; j <= w; j++) begin
        fb.due = 32'(last_edge + j);
        fb.d   = '0;
        flt_q.push_back(fb);
      end
      chk("in_ready_after_feed", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic wait_done(input int limit, output int dcyc);
    for (int n = 0; n < limit && !done; n++) tick();
    chk("done_seen", 32'(done), 32'd1);
    dcyc = cyc;
    tick();
    chk("done_one_pulse", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic drained();
    chk("out_q_drained", 32'(out_q.size()), 32'd0);
    chk("flt_q_drained", 32'(flt_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d;
    // Reset state
    tick(); tick(); tick();
    chk("rst_ctrl", 32'({busy, done, in_ready, flt_valid_o, out_valid}), 32'd0);
    chk("rst_data", 32'(flt_data_o) | 32'(out_data), 32'd0);
    chk("rst_flags", 32'({out_sof, out_eol, out_eof, err_cfg, err_timeout, err_overrun}), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(in_ready), 32'd0);

    // 4x3 continuous frame
    do_start(4, 3, 12);
    chk("busy_on_start", 32'(busy), 32'd1);
    send_frame(4, 3, 12, 12, 1'b0, 8'h11);
    wait_done(4000, d);
    chk("a_errors", 32'({err_cfg, err_timeout, err_overrun}), 32'd0);
    chk("a_eof_before_done", 32'((d - last_eof_cyc) >= 1 && (d - last_eof_cyc) <= 2), 32'd1);
    drained();

    // 8x4 frame with gapped input
    do_start(8, 4, 32);
    send_frame(8, 4, 32, 32, 1'b1, 8'h22);
    wait_done(4000, d);
    chk("b_errors", 32'({err_cfg, err_timeout, err_overrun}), 32'd0);
    drained();

    // Filter stalls after 10 outputs
    do_start(4, 3, 10);
    send_frame(4, 3, 10, 12, 1'b0, 8'h33);
    wait_done(8000, d);
    chk("c_timeout_err", 32'({err_cfg, err_timeout, err_overrun}), 32'b010);
    chk("c_timeout_gap", 32'(d - last_out_cyc), 32'd4096);
    drained();

    // Filter emits one extra output
    do_start(4, 3, 13);
    send_frame(4, 3, 13, 12, 1'b0, 8'h44);
    wait_done(4000, d);
    chk("d_overrun_err", 32'({err_cfg, err_timeout, err_overrun}), 32'b001);
    tick(); tick();
    chk("d_overrun_sticky", 32'(err_overrun), 32'd1);
    drained();

    // Bad width, then a valid 2x2 frame
    do_start(1, 3, 0);
    chk("e_cfg_busy", 32'({busy, done, err_cfg, err_overrun}), 32'b1010);
    tick();
    chk("e_cfg_done", 32'({busy, done}), 32'b01);
    tick();
    chk("e_cfg_done_pulse", 32'(done), 32'd0);
    tick(); tick();
    do_start(2, 2, 4);
    chk("e_cfg_cleared", 32'(err_cfg), 32'd0);
    send_frame(2, 2, 4, 4, 1'b0, 8'h55);
    wait_done(4000, d);
    chk("e_errors", 32'({err_cfg, err_timeout, err_overrun}), 32'd0);
    drained();

    // Reset mid-FEED, then a clean frame with an ignored start while busy
    do_start(4, 3, 12);
    send_frame(4, 3, 12, 5, 1'b0, 8'h66);
    reset = 1'b1;
    flt_q.delete();
    out_q.delete();
    tick();
    chk("f_rst_ctrl", 32'({busy, done, in_ready, flt_valid_o, out_valid}), 32'd0);
    chk("f_rst_data", 32'(flt_data_o) | 32'(out_data), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    do_start(4, 3, 12);
    send_frame(4, 3, 12, 12, 1'b0, 8'h77);
    img_width = 11'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f_busy_kept", 32'(busy), 32'd1);
    wait_done(4000, d);
    chk("f_errors", 32'({err_cfg, err_timeout, err_overrun}), 32'd0);
    drained();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
